// File: rtl/a2d_seq.sv
// rtl/a2d_seq.sv - round-robin A2D sequencer over four channel slots
// Start pulse per slot, edge-qualified capture with timeout, fixed gap between slots.
module a2d_seq #(
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6,
    parameter int         GAP      = 10,
    parameter int         TIMEOUT  = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr_err,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        vld,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP - 1);

    state_t      state;
    logic [1:0]  idx;
    logic [15:0] wait_cnt;
    logic [7:0]  gap_cnt;
    logic        cnv_q;
    logic        capture;
    logic        timeout;
    logic        gap_done;

    function automatic logic [2:0] ch_of(input logic [1:0] i);
        case (i)
            2'd0:    ch_of = CH_LFT;
            2'd1:    ch_of = CH_RGHT;
            2'd2:    ch_of = CH_STEER;
            default: ch_of = CH_BATT;
        endcase
    endfunction

    // Only a fresh rise counts; a level left high by the previous slot is ignored.
    assign capture  = (state == S_WAIT) && cnv_cmplt && !cnv_q;
    assign timeout  = (state == S_WAIT) && !capture && (wait_cnt == WAIT_LAST);
    assign gap_done = (state == S_GAP) && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= 2'd0;
            wait_cnt  <= 16'd0;
            gap_cnt   <= 8'd0;
            cnv_q     <= 1'b0;
            strt_cnv  <= 1'b0;
            chnnl     <= 3'd0;
            lft_ld    <= 12'd0;
            rght_ld   <= 12'd0;
            steer_pot <= 12'd0;
            batt      <= 12'd0;
            vld       <= 1'b0;
            err       <= 1'b0;
        end else begin
            cnv_q    <= cnv_cmplt;
            strt_cnv <= 1'b0;
            vld      <= 1'b0;

            if (timeout) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (en) begin
                        state    <= S_START;
                        strt_cnv <= 1'b1;
                        chnnl    <= ch_of(idx);
                    end
                end
                S_START: begin
                    state    <= S_WAIT;
                    wait_cnt <= 16'd0;
                end
                S_WAIT: begin
                    if (capture) begin
                        case (idx)
                            2'd0:    lft_ld    <= res;
                            2'd1:    rght_ld   <= res;
                            2'd2:    steer_pot <= res;
                            default: batt      <= res;
                        endcase
                        state   <= S_GAP;
                        gap_cnt <= 8'd0;
                    end else if (timeout) begin
                        state   <= S_GAP;
                        gap_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (gap_done) begin
                        vld <= (idx == 2'd3);
                        if (en) begin
                            idx      <= idx + 2'd1;
                            state    <= S_START;
                            strt_cnv <= 1'b1;
                            chnnl    <= ch_of(idx + 2'd1);
                        end else begin
                            idx   <= 2'd0;
                            state <= S_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_seq.sv
// tb/tb_a2d_seq.sv - self-checking bench for a2d_seq
module tb_a2d_seq;

    localparam int G  = 10;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n, en, clr_err, cnv_cmplt;
    logic [11:0] res;
    logic        strt_cnv, vld, err;
    logic [2:0]  chnnl;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;

    a2d_seq #(.GAP(G), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_err(clr_err),
        .cnv_cmplt(cnv_cmplt), .res(res), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
        .vld(vld), .err(err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int vld_cnt    = 0;
    int strt_cnt   = 0;

    typedef struct {
        logic [1:0]  slot;
        logic [11:0] val;
    } exp_t;
    exp_t sb[$];

    logic [2:0]  chans [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
    logic [11:0] vals  [4] = '{12'hA5A, 12'h123, 12'h7FF, 12'hFFF};

    always @(negedge clk) begin
        if (vld) vld_cnt++;
        if (strt_cnv) strt_cnt++;
    end

    function automatic logic [11:0] slot_out(input logic [1:0] s);
        case (s)
            2'd0:    slot_out = lft_ld;
            2'd1:    slot_out = rght_ld;
            2'd2:    slot_out = steer_pot;
            default: slot_out = batt;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_strt(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (strt_cnv) begin
                n = i;
                break;
            end
        end
    endtask

    // Responds to the slot just started: raises cnv_cmplt with v and drops it a clock later.
    task automatic serve(input logic [1:0] slot, input logic [11:0] v);
        exp_t e;
        tick();
        tick();
        cnv_cmplt = 1'b1;
        res       = v;
        e.slot    = slot;
        e.val     = v;
        sb.push_back(e);
        tick();
        cnv_cmplt = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr_err = 1'b0; cnv_cmplt = 1'b0; res = 12'd0;
        tick();
        tick();
        compared++;
        if ({strt_cnv, chnnl, vld, err} !== 6'd0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b expected 000000", {strt_cnv, chnnl, vld, err});
        end
        compared++;
        if ({lft_ld, rght_ld, steer_pot, batt} !== 48'd0) begin
            mismatched++;
            $display("FAIL reset_data: got %h expected 0", {lft_ld, rght_ld, steer_pot, batt});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round();
        int n, vc0;
        exp_t e;
        vc0 = vld_cnt;
        en  = 1'b1;
        wait_strt(5, n);
        compared++;
        if (n !== 1) begin
            mismatched++;
            $display("FAIL round_start_latency: got %0d expected 1", n);
        end
        for (int s = 0; s < 4; s++) begin
            compared++;
            if (chnnl !== chans[s]) begin
                mismatched++;
                $display("FAIL round_chnnl slot %0d: got %0d expected %0d", s, chnnl, chans[s]);
            end
            tick();
            compared++;
            if (strt_cnv !== 1'b0) begin
                mismatched++;
                $display("FAIL round_strt_width slot %0d: got %b expected 0", s, strt_cnv);
            end
            tick();
            cnv_cmplt = 1'b1;
            res       = vals[s];
            e.slot    = 2'(s);
            e.val     = vals[s];
            sb.push_back(e);
            tick();
            cnv_cmplt = 1'b0;
            e = sb.pop_front();
            compared++;
            if (slot_out(e.slot) !== e.val) begin
                mismatched++;
                $display("FAIL round_capture slot %0d: got %h expected %h", e.slot, slot_out(e.slot), e.val);
            end
            wait_strt(40, n);
            if (s == 0) begin
                compared++;
                if (n + 1 !== G + 1) begin
                    mismatched++;
                    $display("FAIL round_gap_latency: got %0d expected %0d", n + 1, G + 1);
                end
            end
        end
        compared++;
        if (vld !== 1'b1 || chnnl !== 3'd0) begin
            mismatched++;
            $display("FAIL round_wrap: got vld=%b chnnl=%0d expected vld=1 chnnl=0", vld, chnnl);
        end
        en = 1'b0;
        serve(2'd0, vals[0]);
        e = sb.pop_front();
        compared++;
        if (slot_out(e.slot) !== e.val) begin
            mismatched++;
            $display("FAIL round_tail_capture: got %h expected %h", slot_out(e.slot), e.val);
        end
        repeat (G + 3) tick();
        compared++;
        if (vld_cnt - vc0 !== 1 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL round_vld_err: got vld_pulses=%0d err=%b expected 1 and 0", vld_cnt - vc0, err);
        end
    endtask

    task automatic test_timeout();
        int n;
        exp_t e;
        en = 1'b1;
        wait_strt(5, n);
        serve(2'd0, 12'h111);
        e = sb.pop_front();
        compared++;
        if (slot_out(e.slot) !== e.val) begin
            mismatched++;
            $display("FAIL to_capture0: got %h expected %h", slot_out(e.slot), e.val);
        end
        wait_strt(40, n);
        serve(2'd1, 12'h222);
        e = sb.pop_front();
        compared++;
        if (slot_out(e.slot) !== e.val) begin
            mismatched++;
            $display("FAIL to_capture1: got %h expected %h", slot_out(e.slot), e.val);
        end
        wait_strt(40, n);
        compared++;
        if (chnnl !== 3'd5) begin
            mismatched++;
            $display("FAIL to_chnnl2: got %0d expected 5", chnnl);
        end
        tick();
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (err) begin
                n = i;
                break;
            end
        end
        compared++;
        if (n !== TO) begin
            mismatched++;
            $display("FAIL to_wait_clocks: got %0d expected %0d", n, TO);
        end
        compared++;
        if (steer_pot !== 12'h7FF) begin
            mismatched++;
            $display("FAIL to_steer_hold: got %h expected 7ff", steer_pot);
        end
        wait_strt(40, n);
        compared++;
        if (chnnl !== 3'd6) begin
            mismatched++;
            $display("FAIL to_chnnl3: got %0d expected 6", chnnl);
        end
        serve(2'd3, 12'h333);
        e = sb.pop_front();
        compared++;
        if (slot_out(e.slot) !== e.val) begin
            mismatched++;
            $display("FAIL to_capture3: got %h expected %h", slot_out(e.slot), e.val);
        end
        wait_strt(40, n);
        compared++;
        if (vld !== 1'b1) begin
            mismatched++;
            $display("FAIL to_vld: got %b expected 1", vld);
        end
        en = 1'b0;
        serve(2'd0, 12'h111);
        void'(sb.pop_front());
        repeat (G + 3) tick();
        compared++;
        if (err !== 1'b1) begin
            mismatched++;
            $display("FAIL to_err_sticky: got %b expected 1", err);
        end
    endtask

    task automatic test_en_drop();
        int n, vc0, sc0;
        exp_t e;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("FAIL drop_clr_err: got %b expected 0", err);
        end
        vc0 = vld_cnt;
        sc0 = strt_cnt;
        en  = 1'b1;
        wait_strt(5, n);
        serve(2'd0, 12'h0AB);
        void'(sb.pop_front());
        wait_strt(40, n);
        tick();
        en = 1'b0;
        tick();
        cnv_cmplt = 1'b1;
        res       = 12'h3C3;
        e.slot    = 2'd1;
        e.val     = 12'h3C3;
        sb.push_back(e);
        tick();
        cnv_cmplt = 1'b0;
        e = sb.pop_front();
        compared++;
        if (rght_ld !== e.val) begin
            mismatched++;
            $display("FAIL drop_capture: got %h expected %h", rght_ld, e.val);
        end
        repeat (G + 5) tick();
        compared++;
        if (strt_cnt - sc0 !== 2 || vld_cnt !== vc0) begin
            mismatched++;
            $display("FAIL drop_idle: got starts=%0d vld_pulses=%0d expected 2 and 0", strt_cnt - sc0, vld_cnt - vc0);
        end
        en = 1'b1;
        wait_strt(5, n);
        compared++;
        if (n !== 1 || chnnl !== 3'd0) begin
            mismatched++;
            $display("FAIL drop_restart: got latency=%0d chnnl=%0d expected 1 and 0", n, chnnl);
        end
        en = 1'b0;
        serve(2'd0, 12'h0AB);
        void'(sb.pop_front());
        repeat (G + 3) tick();
    endtask

    task automatic test_reset_mid();
        int n, sc0;
        en = 1'b1;
        wait_strt(5, n);
        tick();
        rst_n = 1'b0;
        en    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        sc0       = strt_cnt;
        cnv_cmplt = 1'b1;
        res       = 12'hEEE;
        repeat (4) tick();
        compared++;
        if ({lft_ld, rght_ld, steer_pot, batt} !== 48'd0) begin
            mismatched++;
            $display("FAIL rstmid_data: got %h expected 0", {lft_ld, rght_ld, steer_pot, batt});
        end
        compared++;
        if ({strt_cnv, chnnl, vld, err} !== 6'd0 || strt_cnt !== sc0) begin
            mismatched++;
            $display("FAIL rstmid_ctrl: got %b starts=%0d expected 000000 and 0", {strt_cnv, chnnl, vld, err}, strt_cnt - sc0);
        end
        cnv_cmplt = 1'b0;
        tick();
    endtask

    task automatic test_clr_vs_timeout();
        int n;
        en = 1'b1;
        wait_strt(5, n);
        tick();
        repeat (TO - 1) tick();
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("FAIL clrto_early: got %b expected 0", err);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        en      = 1'b0;
        compared++;
        if (err !== 1'b1) begin
            mismatched++;
            $display("FAIL clrto_set_wins: got %b expected 1", err);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("FAIL clrto_clear: got %b expected 0", err);
        end
        repeat (G + 3) tick();
    endtask

    task automatic test_level_hold();
        int n;
        exp_t e;
        en = 1'b1;
        wait_strt(5, n);
        tick();
        tick();
        cnv_cmplt = 1'b1;
        res       = 12'h5A5;
        e.slot    = 2'd0;
        e.val     = 12'h5A5;
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        compared++;
        if (lft_ld !== e.val) begin
            mismatched++;
            $display("FAIL hold_capture0: got %h expected %h", lft_ld, e.val);
        end
        res = 12'h999;
        wait_strt(40, n);
        repeat (5) tick();
        compared++;
        if (rght_ld !== 12'h000) begin
            mismatched++;
            $display("FAIL hold_no_recapture: got %h expected 000", rght_ld);
        end
        cnv_cmplt = 1'b0;
        tick();
        cnv_cmplt = 1'b1;
        res       = 12'h456;
        e.slot    = 2'd1;
        e.val     = 12'h456;
        sb.push_back(e);
        tick();
        cnv_cmplt = 1'b0;
        en        = 1'b0;
        e = sb.pop_front();
        compared++;
        if (rght_ld !== e.val) begin
            mismatched++;
            $display("FAIL hold_capture1: got %h expected %h", rght_ld, e.val);
        end
        repeat (G + 3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round();
        test_timeout();
        test_en_drop();
        test_reset_mid();
        test_clr_vs_timeout();
        test_level_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
